aes192_word_sequencer: RTL
==========================

// Module: aes192_word_sequencer
// PURPOSE
//  Word-serial front/back end for the AES-192 core. Collects a 192-bit key and a 128-bit state
//  as 32-bit words over a valid/ready stream, then issues a single-cycle start to the core.
//  It waits for the core's out_valid, captures the 128-bit result, and returns it as 4 words on
//  a second valid/ready stream. It also watches for a core timeout.
// PARAMETERS
//  TIMEOUT_CYCLES  32  max cycles from aes_start high to aes_out_valid before error (<=63)
//  TO_W            6   width of timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//  clk            in   1    single clock, rising edge
//  rst_n          in   1    asynchronous active-low reset
//  in_valid       in   1    input word valid
//  in_ready       out  1    input word accepted when in_valid & in_ready
//  in_data        in   32   words 0-5 key (key[191:160] first), words 6-9 state ([127:96] first)
//  aes_start      out  1    start to core; exactly 1 cycle high per block
//  aes_key        out  192  assembled key to core
//  aes_state      out  128  assembled plaintext state to core
//  aes_out        in   128  core result
//  aes_out_valid  in   1    core result valid, 1-cycle pulse
//  out_valid      out  1    result word valid
//  out_ready      in   1    result word consumed when out_valid & out_ready
//  out_data       out  32   result words, aes_out[127:96] first
//  busy           out  1    high in every state except LOAD
//  err            out  1    1-cycle pulse on core timeout
// BEHAVIOUR
//  Reset: all outputs 0; aes_key, aes_state and result buffer 0; state=LOAD; word cnt=0.
//  FSM: LOAD -> START -> WAIT -> DRAIN -> LOAD.
//   LOAD: in_ready=1.
//    - Each accepted word shifts into its key/state register and increments cnt (0..9).
//    - Acceptance of word 9 moves to START next cycle; cnt returns to 0.
//   START: aes_start=1 for this cycle only; in_ready=0; timeout counter cleared to 0; -> WAIT.
//   WAIT: in_ready=0; timeout counter increments each cycle.
//    - aes_out_valid: capture aes_out into the result buffer; -> DRAIN.
//    - Counter reaching TIMEOUT_CYCLES-1 without aes_out_valid: err=1 for 1 cycle;
//      -> LOAD with cnt=0.
//    - aes_out_valid in the same cycle as expiry: valid wins; no err.
//   DRAIN: out_valid=1 with out_data=word[idx].
//    - out_data is held stable until out_ready.
//    - idx advances on each handshake.
//    - Handshake on idx=3 -> LOAD; out_valid drops in the next cycle.
//  Latency: word-9 handshake at edge E -> aes_start high in cycle E+1.
//   Result word 0 is valid the cycle after aes_out_valid.
//  aes_out_valid seen in LOAD/START/DRAIN: ignored.
//  in_valid outside LOAD: ignored; no word consumed.
//  aes_start low >= 11 cycles between pulses, so the core rising-edge detect always fires.
//  aes_key/aes_state are stable from cycle E+1 through the end of START.
//  Reset mid-operation: immediate abort to reset values; no aes_start/err/out_valid glitch.
// CONFIGURATION
//  AES192_KEY_ZEROIZE_EN defined:
//   - aes_key cleared to 0 at the edge ending START (the core has already latched it).
//   - Result buffer cleared to 0 on the idx=3 handshake and on timeout.
//   - out_data reads 0 when out_valid=0.
//  Undefined:
//   - Key and result remain in registers until overwritten by the next block.
//   - out_data holds the last word.
// TESTING
//  1. FIPS-197 C.2: key 000102..1617, pt 00112233..eeff -> aes_start 1 cycle;
//     out words dda97ca4,864cdfe0,6eaf70a0,ec0d7191.
//  2. in_valid toggling 1-0-1 every cycle while loading -> only valid words counted;
//     aes_start only after 10th.
//  3. out_ready held low 5 cycles on word 2 -> out_data stays 6eaf70a0; order preserved.
//  4. Core model never pulses aes_out_valid -> err pulse at start+TIMEOUT_CYCLES;
//     in_ready=1 next cycle; fresh 10-word load works.
//  5. rst_n low during WAIT and again mid-DRAIN -> all outputs 0 asynchronously;
//     clean restart with vector 1.
//  6. With AES192_KEY_ZEROIZE_EN: aes_key==0 the cycle after aes_start; out_data==0 after
//     last readout. Without it: aes_key retains the key.

Source files
------------

// File: rtl/aes192_word_sequencer.sv
// ---------------------------------------------------------------------------
// aes192_word_sequencer
//
// Word-serial front/back end for an AES-192 core. Ten 32-bit words arrive on
// the input stream. Words 0-5 form the key, key[191:160] first. Words 6-9 form
// the plaintext state, state[127:96] first. The block then issues a one-cycle
// aes_start and waits for the core's aes_out_valid pulse. It captures the
// 128-bit result and returns it as four words, aes_out[127:96] first. If the
// core does not answer within TIMEOUT_CYCLES, the block pulses err and goes
// back to loading.
//
// Optional feature (macro AES192_KEY_ZEROIZE_EN):
//   - aes_key is cleared once the core has latched it (at the edge ending START).
//   - The result buffer is cleared after the last readout and on timeout.
//   - out_data reads 0 whenever out_valid is low.
// Without the macro, the key and the result remain in their registers until
// the next block overwrites them, and out_data holds the last word.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   in_valid       input word valid
//   in_ready       input word accepted when in_valid & in_ready
//   in_data[31:0]  input word
//   aes_start      one-cycle start pulse to the core
//   aes_key[191:0] assembled key
//   aes_state[127:0] assembled plaintext state
//   aes_out[127:0] core result
//   aes_out_valid  core result valid (1-cycle pulse)
//   out_valid      result word valid
//   out_ready      result word consumed when out_valid & out_ready
//   out_data[31:0] result word
//   busy           high in every state except LOAD
//   err            one-cycle pulse on core timeout
// ---------------------------------------------------------------------------
module aes192_word_sequencer #(
    parameter int TIMEOUT_CYCLES = 32,
    parameter int TO_W           = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    output logic         aes_start,
    output logic [191:0] aes_key,
    output logic [127:0] aes_state,
    input  logic [127:0] aes_out,
    input  logic         aes_out_valid,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         busy,
    output logic         err
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state_reg, state_next;
    logic [3:0]      cnt_reg;
    logic [TO_W-1:0] tcnt_reg;
    logic [1:0]      idx_reg;
    logic [191:0]    key_reg;
    logic [127:0]    pt_reg;
    logic [127:0]    res_reg;

    logic            in_accept;
    logic            capture;
    logic            timeout;
    logic            out_hs;
    logic            last_hs;
    logic [31:0]     res_word;

    assign in_accept = (state_reg == LOAD) && in_valid;
    assign capture   = (state_reg == WAIT) && aes_out_valid;
    // A result arriving on the expiry cycle wins over the timeout.
    assign timeout   = (state_reg == WAIT) && (tcnt_reg == TO_LAST) && !aes_out_valid;
    assign out_hs    = (state_reg == DRAIN) && out_ready;
    assign last_hs   = out_hs && (idx_reg == 2'd3);
    assign res_word  = res_reg[32*(3 - int'(idx_reg)) +: 32];

    // Next-state and decoded outputs.
    always_comb begin
        state_next = state_reg;
        // LOAD is the reset state, so in_ready is gated with rst_n.
        // This keeps every output low while reset is held.
        in_ready   = rst_n && (state_reg == LOAD);
        aes_start  = (state_reg == START);
        busy       = (state_reg != LOAD);
        out_valid  = (state_reg == DRAIN);
        err        = timeout;
        case (state_reg)
            LOAD:  if (in_accept && cnt_reg == 4'd9) state_next = START;
            START: state_next = WAIT;
            WAIT: begin
                if (aes_out_valid) state_next = DRAIN;
                else if (timeout)  state_next = LOAD;
            end
            DRAIN: if (last_hs) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= LOAD;
            cnt_reg   <= '0;
            tcnt_reg  <= '0;
            idx_reg   <= '0;
            key_reg   <= '0;
            pt_reg    <= '0;
            res_reg   <= '0;
        end else begin
            state_reg <= state_next;

            // Word counter and shift-in of key and state.
            if (in_accept) begin
                cnt_reg <= (cnt_reg == 4'd9) ? 4'd0 : cnt_reg + 4'd1;
                if (cnt_reg < 4'd6) key_reg <= {key_reg[159:0], in_data};
                else                pt_reg  <= {pt_reg[95:0], in_data};
            end
`ifdef AES192_KEY_ZEROIZE_EN
            else if (state_reg == START) begin
                key_reg <= '0;
            end
`endif

            // Timeout counter: cleared in START, counts while waiting.
            if (state_reg == START)     tcnt_reg <= '0;
            else if (state_reg == WAIT) tcnt_reg <= tcnt_reg + 1'b1;

            // Result buffer and readout index. The index parks on word 3
            // after the final handshake, so out_data can keep showing it.
            if (capture) begin
                res_reg <= aes_out;
                idx_reg <= 2'd0;
            end else if (out_hs && !last_hs) begin
                idx_reg <= idx_reg + 2'd1;
            end
`ifdef AES192_KEY_ZEROIZE_EN
            if (last_hs || timeout) res_reg <= '0;
`endif
        end
    end

    assign aes_key   = key_reg;
    assign aes_state = pt_reg;

`ifdef AES192_KEY_ZEROIZE_EN
    assign out_data = out_valid ? res_word : 32'd0;
`else
    assign out_data = res_word;
`endif

endmodule
